timer_interface: RTL and testbench
==================================

Name: timer_interface

Overview:
- Memory-mapped timer peripheral and a bus follower on the system bus, alongside led_interface and rom.
- Responds to leader reads and writes with byte-enable support and fixed read latency.
- Provides a prescaled up-counter, compare match, sticky status and a level interrupt output.
- The system bus decodes the timer's base address; the block decodes only addr[4:2].

Parameters:
CountWidth, 32, counter and compare width; 1..32; unused upper read bits return 0
PrescaleReset, 0, reset value of CTRL.prescale (tick every PrescaleReset+1 cycles)

Ports:
clk  input  1  system clock, all state on posedge
reset  input  1  asynchronous, active-high; clears all state immediately
addr  input  32  byte address; only addr[4:2] decoded
write_req  input  1  single-cycle write strobe
write_data  input  32  write data
byte_enable  input  4  per-byte write mask, bit n = write_data[8n+7:8n]
read_req  input  1  single-cycle read strobe
read_data  output  32  registered read data
read_data_valid  output  1  high exactly one cycle after read_req
irq  output  1  status.match AND ctrl.irq_en

Behaviour:
- Register map, word index addr[4:2]:
  - 0 CTRL: [0] enable, [1] auto_reload, [2] irq_en, [31:16] prescale.
  - 1 COUNT: read/write.
  - 2 COMPARE: read/write.
  - 3 STATUS: [0] match; write-1-to-clear.
  - 4 CAPTURE (optional).
  - Others: read 0, writes ignored.
- Reset values: CTRL = {PrescaleReset, 16'h0}; COUNT = 0; COMPARE = all ones; STATUS = 0; read_data = 0; read_data_valid = 0; irq = 0. Reset mid-operation aborts any pending read response.
- Reads: read_req at cycle N produces read_data_valid = 1 at N+1, with read_data holding the register value sampled at N. When read_data_valid = 0, read_data = 0. Back-to-back reads are supported, one per cycle.
- Writes: take effect on the clock edge of write_req. Only bytes with byte_enable set are updated; reserved CTRL bits [15:3] read 0. byte_enable = 0 is a no-op.
- Simultaneous read_req and write_req to the same register: read returns the pre-write value.
- Prescaler: an internal counter, pre_cnt, runs only while enable = 1. When pre_cnt == prescale, pre_cnt returns to 0 and a tick is asserted; otherwise pre_cnt increments. Clearing enable resets pre_cnt to 0. Writing CTRL.prescale also resets pre_cnt.
- Counter, on each tick:
  - If COUNT == COMPARE: set STATUS.match. If auto_reload = 1, COUNT becomes 0 and enable stays 1. If auto_reload = 0, COUNT holds and enable clears to 0.
  - Otherwise: COUNT increments, wrapping from 2^CountWidth-1 to 0 without setting match.
- Priorities:
  - CPU write to COUNT beats a tick in the same cycle.
  - Hardware clearing of enable beats a CPU write that sets enable in the same cycle.
  - Match set beats W1C clear in the same cycle.
- irq is combinational from registered STATUS and CTRL state, so it is glitch-free relative to clk.

Optional Feature:
- Macro: TIMER_CAPTURE_EN.
- Defined:
  - Adds port capture_in, input, 1 bit, asynchronous.
  - capture_in passes through a 2-flop synchroniser.
  - A rising edge of the synchronised signal copies COUNT into CAPTURE (index 4) and sets STATUS[1] capture, which is W1C.
  - irq becomes (match OR capture) AND irq_en.
- Not defined: no capture_in port; index 4 reads 0; STATUS[1] reads 0.

Test Plan:
- Reset with reset = 1 mid-count (COUNT = 7) -> all registers return to reset values immediately; irq = 0 and read_data_valid = 0 at the next edge.
- Read COMPARE after reset -> read_data_valid high exactly one cycle later with read_data = 32'hFFFFFFFF. Read address 0x1C -> 0.
- Write COMPARE = 3, then CTRL = 32'h0001_0007 (prescale 1, enable, auto_reload, irq_en) -> COUNT advances every 2 cycles through 0,1,2,3,0. match and irq rise on the 3-to-0 tick. Write STATUS = 1 -> irq falls the next cycle.
- With auto_reload = 0, COMPARE = 2, prescale 0 -> COUNT stops at 2, enable reads 0 and match = 1. A write setting enable in the cycle of the stop is overridden, so enable still reads 0.
- Byte write to COUNT = 32'hAABBCCDD with byte_enable = 4'b0010 from COUNT = 0 -> COUNT = 32'h0000CC00. Writing COUNT in the same cycle as a tick -> the written value wins. Simultaneous read of COUNT returns the old value.
- (TIMER_CAPTURE_EN) Raise capture_in while COUNT = 10 with prescale 0 -> CAPTURE holds COUNT as of the synchronised edge (12 ±1 per the synchroniser latency), and STATUS[1] = 1.

Source files
------------

// File: rtl/timer_interface.sv
// timer_interface: memory-mapped prescaled timer with compare match and irq.
// Bus follower on the system bus; decodes only addr[4:2].
//
// Ports:
//   clk, reset        system clock, async active-high reset
//   addr              byte address, word index addr[4:2]
//   write_req         single-cycle write strobe
//   write_data        write data
//   byte_enable       per-byte write mask
//   read_req          single-cycle read strobe
//   read_data         registered read data, 0 when not valid
//   read_data_valid   high one cycle after read_req
//   irq               level interrupt, status AND irq_en
//   capture_in        async capture input (TIMER_CAPTURE_EN only)
//
// Registers (addr[4:2]):
//   0 CTRL     [0] enable [1] auto_reload [2] irq_en [31:16] prescale
//   1 COUNT    2 COMPARE    3 STATUS [0] match [1] capture (W1C)
//   4 CAPTURE  (TIMER_CAPTURE_EN only, else reads 0)
//
// Optional feature macro: TIMER_CAPTURE_EN.

module timer_interface #(
   parameter int          CountWidth    = 32,
   parameter logic [15:0] PrescaleReset = 16'h0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic        write_req,
   input  logic [31:0] write_data,
   input  logic [3:0]  byte_enable,
   input  logic        read_req,
`ifdef TIMER_CAPTURE_EN
   input  logic        capture_in,
`endif
   output logic [31:0] read_data,
   output logic        read_data_valid,
   output logic        irq
);

   typedef logic [CountWidth-1:0] cnt_t;

   logic        ctrl_en;
   logic        ctrl_ar;
   logic        ctrl_irq_en;
   logic [15:0] prescale;
   logic [15:0] pre_cnt;
   cnt_t        count;
   cnt_t        compare;
   logic        st_match;

   logic [2:0]  idx;
   logic        sel_ctrl;
   logic        sel_count;
   logic        sel_cmp;
   logic        sel_stat;
   logic        sel_cap;

   logic        wr_ctrl;
   logic        wr_count;
   logic        wr_cmp;
   logic        ps_wr;
   logic        w1c_match;

   logic        tick;
   logic        hit;
   logic        stop;

   logic [31:0] count_wr;
   logic [31:0] cmp_wr;
   logic [31:0] status_rd;
   logic [31:0] cap_rd;
   logic [31:0] rd_mux;

   logic        unused_addr;

   function automatic logic [31:0] merge(
      input logic [31:0] old,
      input logic [31:0] d,
      input logic [3:0]  be
   );
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) r[8*i +: 8] = d[8*i +: 8];
      end
      return r;
   endfunction

   assign unused_addr = ^{addr[31:5], addr[1:0]};

   assign idx       = addr[4:2];
   assign sel_ctrl  = (idx == 3'd0);
   assign sel_count = (idx == 3'd1);
   assign sel_cmp   = (idx == 3'd2);
   assign sel_stat  = (idx == 3'd3);
   assign sel_cap   = (idx == 3'd4);

   assign wr_ctrl   = write_req && sel_ctrl;
   assign wr_count  = write_req && sel_count && (|byte_enable);
   assign wr_cmp    = write_req && sel_cmp;
   assign ps_wr     = wr_ctrl && (byte_enable[2] || byte_enable[3]);
   assign w1c_match = write_req && sel_stat
                      && byte_enable[0] && write_data[0];

   assign tick = ctrl_en && (pre_cnt == prescale);
   assign hit  = (count == compare);
   // One-shot mode: the matching tick parks the timer.
   assign stop = tick && hit && !ctrl_ar;

   assign count_wr = merge(32'(count), write_data, byte_enable);
   assign cmp_wr   = merge(32'(compare), write_data, byte_enable);

`ifdef TIMER_CAPTURE_EN
   logic cap_s1;
   logic cap_s2;
   logic cap_d;
   logic cap_rise;
   logic st_cap;
   cnt_t capture;
   logic w1c_cap;

   assign cap_rise  = cap_s2 && !cap_d;
   assign w1c_cap   = write_req && sel_stat
                      && byte_enable[0] && write_data[1];
   assign status_rd = {30'h0, st_cap, st_match};
   assign cap_rd    = 32'(capture);
   assign irq       = (st_match || st_cap) && ctrl_irq_en;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cap_s1  <= 1'b0;
         cap_s2  <= 1'b0;
         cap_d   <= 1'b0;
         st_cap  <= 1'b0;
         capture <= '0;
      end else begin
         cap_s1 <= capture_in;
         cap_s2 <= cap_s1;
         cap_d  <= cap_s2;
         if (cap_rise) begin
            capture <= count;
            st_cap  <= 1'b1;
         end else if (w1c_cap) begin
            st_cap  <= 1'b0;
         end
      end
   end
`else
   assign status_rd = {31'h0, st_match};
   assign cap_rd    = 32'h0;
   assign irq       = st_match && ctrl_irq_en;
`endif

   always_comb begin
      rd_mux = 32'h0;
      unique case (1'b1)
         sel_ctrl:  rd_mux = {prescale, 13'h0,
                             ctrl_irq_en, ctrl_ar, ctrl_en};
         sel_count: rd_mux = 32'(count);
         sel_cmp:   rd_mux = 32'(compare);
         sel_stat:  rd_mux = status_rd;
         sel_cap:   rd_mux = cap_rd;
         default:   rd_mux = 32'h0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctrl_en         <= 1'b0;
         ctrl_ar         <= 1'b0;
         ctrl_irq_en     <= 1'b0;
         prescale        <= PrescaleReset;
         pre_cnt         <= 16'h0;
         count           <= '0;
         compare         <= '1;
         st_match        <= 1'b0;
         read_data       <= 32'h0;
         read_data_valid <= 1'b0;
      end else begin
         if (wr_ctrl && byte_enable[0]) begin
            ctrl_en     <= write_data[0];
            ctrl_ar     <= write_data[1];
            ctrl_irq_en <= write_data[2];
         end
         if (wr_ctrl && byte_enable[2])
            prescale[7:0] <= write_data[23:16];
         if (wr_ctrl && byte_enable[3])
            prescale[15:8] <= write_data[31:24];
         // Hardware stop overrides a CPU enable write.
         if (stop)
            ctrl_en <= 1'b0;

         if (!ctrl_en || ps_wr || tick)
            pre_cnt <= 16'h0;
         else
            pre_cnt <= pre_cnt + 16'd1;

         // CPU write wins over the tick.
         if (wr_count)
            count <= count_wr[CountWidth-1:0];
         else if (tick && !hit)
            count <= count + CountWidth'(1);
         else if (tick && hit && ctrl_ar)
            count <= '0;

         if (wr_cmp)
            compare <= cmp_wr[CountWidth-1:0];

         // Set beats W1C clear.
         if (tick && hit)
            st_match <= 1'b1;
         else if (w1c_match)
            st_match <= 1'b0;

         read_data_valid <= read_req;
         read_data       <= read_req ? rd_mux : 32'h0;
      end
   end

endmodule

// File: tb/tb_timer_interface.sv
// tb_timer_interface: directed and randomized checks of timer_interface.
// Expected values come from closed-form tick arithmetic.

module tb_timer_interface;

   localparam logic [31:0] A_CTRL  = 32'h00;
   localparam logic [31:0] A_COUNT = 32'h04;
   localparam logic [31:0] A_CMP   = 32'h08;
   localparam logic [31:0] A_STAT  = 32'h0C;
   localparam logic [31:0] A_CAP   = 32'h10;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] addr;
   logic        write_req;
   logic [31:0] write_data;
   logic [3:0]  byte_enable;
   logic        read_req;
   logic [31:0] read_data;
   logic        read_data_valid;
   logic        irq;
`ifdef TIMER_CAPTURE_EN
   logic        capture_in;
`endif

   int total = 0;
   int bad   = 0;

   logic [31:0] d;
   logic        v;
   logic [31:0] cw;
   int          p;
   int          c;
   int          n;
   bit          ar;

   timer_interface dut (
      .clk             (clk),
      .reset           (reset),
      .addr            (addr),
      .write_req       (write_req),
      .write_data      (write_data),
      .byte_enable     (byte_enable),
      .read_req        (read_req),
`ifdef TIMER_CAPTURE_EN
      .capture_in      (capture_in),
`endif
      .read_data       (read_data),
      .read_data_valid (read_data_valid),
      .irq             (irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // All bus tasks start and end on a falling edge.
   task automatic idle(input int k);
      repeat (k) @(negedge clk);
   endtask

   task automatic wr(input logic [31:0] a,
                     input logic [31:0] wd,
                     input logic [3:0]  be);
      addr = a; write_data = wd; byte_enable = be;
      write_req = 1'b1;
      @(negedge clk);
      write_req = 1'b0; byte_enable = 4'h0;
   endtask

   task automatic rd(input  logic [31:0] a,
                     output logic [31:0] rdat,
                     output logic        rv);
      addr = a; read_req = 1'b1;
      @(negedge clk);
      read_req = 1'b0;
      rdat = read_data; rv = read_data_valid;
   endtask

   task automatic rdchk(input string tag,
                        input logic [31:0] a,
                        input logic [31:0] exp);
      logic [31:0] rdat;
      logic        rv;
      rd(a, rdat, rv);
      chk({tag, "_valid"}, 32'(rv), 32'h1);
      chk(tag, rdat, exp);
   endtask

   task automatic rdwr(input  logic [31:0] a,
                       input  logic [31:0] wd,
                       output logic [31:0] rdat);
      addr = a; write_data = wd; byte_enable = 4'hF;
      write_req = 1'b1; read_req = 1'b1;
      @(negedge clk);
      write_req = 1'b0; read_req = 1'b0; byte_enable = 4'h0;
      rdat = read_data;
   endtask

   // Model: m edges after enabling, ticks = m/(p+1).
   function automatic int mt(input int m, input int pp);
      return m / (pp + 1);
   endfunction

   function automatic logic [31:0] mcnt(input int t, input int cc,
                                        input bit a);
      if (a) return 32'(t % (cc + 1));
      return 32'((t < cc) ? t : cc);
   endfunction

   function automatic logic mmatch(input int t, input int cc);
      return t > cc;
   endfunction

   function automatic logic men(input int t, input int cc,
                                input bit a);
      return a || (t <= cc);
   endfunction

   initial begin
      reset = 1'b1; addr = 32'h0; write_req = 1'b0;
      write_data = 32'h0; byte_enable = 4'h0; read_req = 1'b0;
`ifdef TIMER_CAPTURE_EN
      capture_in = 1'b0;
`endif
      idle(2);
      chk("rst_rdata", read_data, 32'h0);
      chk("rst_valid", 32'(read_data_valid), 32'h0);
      chk("rst_irq", 32'(irq), 32'h0);
      reset = 1'b0;
      idle(1);

      rdchk("rst_cmp", A_CMP, 32'hFFFF_FFFF);
      chk("valid_drop", 32'(read_data_valid), 32'h1);
      idle(1);
      chk("valid_low", 32'(read_data_valid), 32'h0);
      chk("data_low", read_data, 32'h0);
      rdchk("rst_ctrl", A_CTRL, 32'h0);
      rdchk("rst_count", A_COUNT, 32'h0);
      rdchk("rst_stat", A_STAT, 32'h0);
      rdchk("unmapped_1c", 32'h1C, 32'h0);
      rdchk("unmapped_14", 32'h14, 32'h0);
`ifndef TIMER_CAPTURE_EN
      rdchk("cap_absent", A_CAP, 32'h0);
`endif

      // Auto-reload, prescale 1, compare 3.
      wr(A_CMP, 32'd3, 4'hF);
      wr(A_CTRL, 32'h0001_0007, 4'hF);
      for (int s = 0; s < 9; s++) begin
         rd(A_COUNT, d, v);
         chk("seq_valid", 32'(v), 32'h1);
         chk("seq_count", d, mcnt(mt(s, 1), 3, 1'b1));
      end
      chk("seq_irq", 32'(irq), 32'(mmatch(mt(9, 1), 3)));
      wr(A_STAT, 32'h1, 4'h1);
      chk("w1c_irq", 32'(irq), 32'h0);

      // One-shot stop with a racing enable write.
      wr(A_CTRL, 32'h0, 4'hF);
      wr(A_COUNT, 32'h0, 4'hF);
      wr(A_CMP, 32'd2, 4'hF);
      wr(A_STAT, 32'h1, 4'h1);
      wr(A_CTRL, 32'h5, 4'hF);
      idle(2);
      wr(A_CTRL, 32'h5, 4'h1);
      rdchk("stop_ctrl", A_CTRL, 32'h4);
      rdchk("stop_count", A_COUNT, 32'd2);
      rdchk("stop_stat", A_STAT, 32'h1);
      chk("stop_irq", 32'(irq), 32'h1);

      // Byte enables and write/tick/read collisions.
      wr(A_CTRL, 32'h0, 4'hF);
      wr(A_STAT, 32'h1, 4'h1);
      wr(A_COUNT, 32'h0, 4'hF);
      wr(A_COUNT, 32'hAABB_CCDD, 4'b0010);
      rdchk("byte_wr", A_COUNT, 32'h0000_CC00);
      wr(A_COUNT, 32'hFFFF_FFFF, 4'h0);
      rdchk("be_zero", A_COUNT, 32'h0000_CC00);
      wr(A_CTRL, 32'hFFFF_FFF8, 4'h1);
      rdchk("ctrl_rsvd", A_CTRL, 32'h0);
      wr(A_CMP, 32'd100, 4'hF);
      wr(A_COUNT, 32'h0, 4'hF);
      wr(A_CTRL, 32'h1, 4'hF);
      idle(3);
      rdwr(A_COUNT, 32'h50, d);
      chk("rw_old", d, 32'd3);
      rdchk("wr_beats_tick", A_COUNT, 32'h50);

      // Randomized trials against the closed-form model.
      for (int k = 0; k < 24; k++) begin
         p  = int'($urandom_range(0, 3));
         c  = int'($urandom_range(0, 6));
         ar = 1'($urandom_range(0, 1));
         n  = int'($urandom_range(0, 30));
         wr(A_CTRL, 32'h0, 4'hF);
         wr(A_COUNT, 32'h0, 4'hF);
         wr(A_CMP, 32'(c), 4'hF);
         wr(A_STAT, 32'h1, 4'h1);
         cw = (32'(p) << 16) | 32'h5 | (ar ? 32'h2 : 32'h0);
         wr(A_CTRL, cw, 4'hF);
         idle(n);
         rdchk("rnd_count", A_COUNT, mcnt(mt(n, p), c, ar));
         rdchk("rnd_stat", A_STAT,
               32'(mmatch(mt(n + 1, p), c)));
         cw = (32'(p) << 16) | 32'h4 | (ar ? 32'h2 : 32'h0)
              | 32'(men(mt(n + 2, p), c, ar));
         rdchk("rnd_ctrl", A_CTRL, cw);
         chk("rnd_irq", 32'(irq), 32'(mmatch(mt(n + 3, p), c)));
      end

      // Reset mid-count with a pending read response.
      wr(A_CTRL, 32'h0, 4'hF);
      wr(A_COUNT, 32'h0, 4'hF);
      wr(A_CMP, 32'd7, 4'hF);
      wr(A_STAT, 32'h1, 4'h1);
      wr(A_CTRL, 32'h5, 4'hF);
      idle(8);
      chk("pre_rst_irq", 32'(irq), 32'h1);
      addr = A_COUNT; read_req = 1'b1;
      @(posedge clk);
      #1 read_req = 1'b0;
      chk("pend_valid", 32'(read_data_valid), 32'h1);
      chk("pend_data", read_data, 32'd7);
      #2 reset = 1'b1;
      #1;
      chk("abort_valid", 32'(read_data_valid), 32'h0);
      chk("abort_data", read_data, 32'h0);
      chk("abort_irq", 32'(irq), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      rdchk("post_count", A_COUNT, 32'h0);
      rdchk("post_cmp", A_CMP, 32'hFFFF_FFFF);
      rdchk("post_ctrl", A_CTRL, 32'h0);
      rdchk("post_stat", A_STAT, 32'h0);

`ifdef TIMER_CAPTURE_EN
      wr(A_COUNT, 32'd10, 4'hF);
      wr(A_CTRL, 32'h1, 4'hF);
      capture_in = 1'b1;
      idle(5);
      rd(A_CAP, d, v);
      chk("cap_range", 32'(d >= 32'd11 && d <= 32'd13), 32'h1);
      rd(A_STAT, d, v);
      chk("cap_stat", d & 32'h2, 32'h2);
      wr(A_CTRL, 32'h0, 4'hF);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
